qerv_rf_ram_arb: RTL and testbench

QERV_RF_RAM_ARB -- requirements
Module: qerv_rf_ram_arb

---
 rtl/qerv_rf_ram_arb.sv | 106 ++++++++++
 tb/tb_qerv_rf_ram_arb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/qerv_rf_ram_arb.sv
// Register-file RAM arbiter: clears the RAM after reset, then passes the core
// through and slots host accesses into cycles where the needed RAM port is idle.
module qerv_rf_ram_arb #(
    parameter int width   = 8,
    parameter int aw      = 8,
    parameter int depth   = 144,
    parameter int init_en = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [aw-1:0]    i_c_waddr,
    input  logic [width-1:0] i_c_wdata,
    input  logic             i_c_wen,
    input  logic [aw-1:0]    i_c_raddr,
    input  logic             i_c_ren,
    output logic [width-1:0] o_c_rdata,
    output logic             o_init_done,
    input  logic             i_h_stb,
    input  logic             i_h_we,
    input  logic [aw-1:0]    i_h_addr,
    input  logic [width-1:0] i_h_wdata,
    output logic             o_h_ack,
    output logic [width-1:0] o_h_rdata,
    output logic [aw-1:0]    o_waddr,
    output logic [width-1:0] o_wdata,
    output logic             o_wen,
    output logic [aw-1:0]    o_raddr,
    output logic             o_ren,
    input  logic [width-1:0] i_rdata
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [aw-1:0] LAST_ADDR = aw'(depth - 1);

    state_t        state_q, state_d;
    logic [aw-1:0] clr_cnt_q, clr_cnt_d;
    logic          ack_q, ack_d;
    logic          grant;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= (init_en != 0) ? INIT : RUN;
            clr_cnt_q <= '0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ack_q     <= ack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        ack_d       = 1'b0;
        grant       = 1'b0;
        o_wen       = 1'b0;
        o_waddr     = i_c_waddr;
        o_wdata     = i_c_wdata;
        o_ren       = 1'b0;
        o_raddr     = i_c_raddr;
        o_init_done = 1'b0;
        o_h_ack     = 1'b0;

        // Enables are gated by i_rst so nothing reaches the RAM during reset,
        // even before the state register has been re-initialised.
        if (!i_rst) begin
            case (state_q)
                INIT: begin
                    o_wen   = 1'b1;
                    o_waddr = clr_cnt_q;
                    o_wdata = '0;
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_d = RUN;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    o_init_done = 1'b1;
                    o_h_ack     = ack_q;
                    o_wen       = i_c_wen;
                    o_ren       = i_c_ren;
                    // The ack cycle never grants, capping the host at one access per two cycles.
                    grant = i_h_stb && !ack_q && (i_h_we ? !i_c_wen : !i_c_ren);
                    ack_d = grant;
                    if (grant && i_h_we) begin
                        o_wen   = 1'b1;
                        o_waddr = i_h_addr;
                        o_wdata = i_h_wdata;
                    end
                    if (grant && !i_h_we) begin
                        o_ren   = 1'b1;
                        o_raddr = i_h_addr;
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

    assign o_c_rdata = i_rdata;
    assign o_h_rdata = i_rdata;

endmodule

// File: tb/tb_qerv_rf_ram_arb.sv
// Directed bench for qerv_rf_ram_arb with a behavioural registered-read RAM.
module tb_qerv_rf_ram_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] c_waddr, c_wdata, c_raddr, h_addr, h_wdata;
    logic       c_wen, c_ren, h_stb, h_we;
    logic [7:0] c_rdata, h_rdata, waddr, wdata, raddr, rdata;
    logic       init_done, h_ack, wen, ren;

    logic [7:0] z8 = 8'h00;
    logic       z1 = 1'b0;
    logic [7:0] c_rdata2, h_rdata2, waddr2, wdata2, raddr2;
    logic       init_done2, h_ack2, wen2, ren2;

    logic [7:0] mem [0:255];
    int         n_pass = 0;
    int         n_total = 0;

    always #5 clk = ~clk;

    // Registered-read RAM; a read and write to the same address return the old word.
    always @(posedge clk) begin
        if (wen) mem[waddr] <= wdata;
        if (ren) rdata <= mem[raddr];
    end

    qerv_rf_ram_arb #(.width(8), .aw(8), .depth(144), .init_en(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_c_waddr(c_waddr), .i_c_wdata(c_wdata), .i_c_wen(c_wen),
        .i_c_raddr(c_raddr), .i_c_ren(c_ren), .o_c_rdata(c_rdata),
        .o_init_done(init_done),
        .i_h_stb(h_stb), .i_h_we(h_we), .i_h_addr(h_addr), .i_h_wdata(h_wdata),
        .o_h_ack(h_ack), .o_h_rdata(h_rdata),
        .o_waddr(waddr), .o_wdata(wdata), .o_wen(wen),
        .o_raddr(raddr), .o_ren(ren), .i_rdata(rdata)
    );

    qerv_rf_ram_arb #(.width(8), .aw(8), .depth(4), .init_en(0)) dut_noinit (
        .i_clk(clk), .i_rst(rst),
        .i_c_waddr(z8), .i_c_wdata(z8), .i_c_wen(z1),
        .i_c_raddr(z8), .i_c_ren(z1), .o_c_rdata(c_rdata2),
        .o_init_done(init_done2),
        .i_h_stb(z1), .i_h_we(z1), .i_h_addr(z8), .i_h_wdata(z8),
        .o_h_ack(h_ack2), .o_h_rdata(h_rdata2),
        .o_waddr(waddr2), .o_wdata(wdata2), .o_wen(wen2),
        .o_raddr(raddr2), .o_ren(ren2), .i_rdata(z8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1;
        c_wen = 1'b1; c_waddr = 8'd1; c_wdata = 8'hFF;
        c_ren = 1'b1; c_raddr = 8'd2;
        h_stb = 1'b0; h_we = 1'b0; h_addr = 8'd0; h_wdata = 8'd0;

        // Reset held with core enables high: nothing may reach the RAM
        @(negedge clk); #1;
        chk("rst_wen", wen, 1'b0);
        chk("rst_ren", ren, 1'b0);
        chk("rst_ack", h_ack, 1'b0);
        chk("rst_done", init_done, 1'b0);
        chk("rst_done_noinit", init_done2, 1'b0);

        // First clear, interrupted at clr_cnt = 50
        @(negedge clk);
        rst = 1'b0; c_wen = 1'b0; c_ren = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            chk("clr1_wen", wen, 1'b1);
            chk("clr1_waddr", waddr, i);
            if (i == 0) begin
                chk("noinit_done", init_done2, 1'b1);
                chk("noinit_wen", wen2, 1'b0);
            end
            @(negedge clk);
        end
        rst = 1'b1; c_wen = 1'b1; c_ren = 1'b1;
        #1;
        chk("abort_wen", wen, 1'b0);
        chk("abort_ren", ren, 1'b0);
        chk("abort_done", init_done, 1'b0);
        @(negedge clk); #1;
        chk("abort2_wen", wen, 1'b0);
        chk("abort2_done", init_done, 1'b0);

        // Full clear with a host write waiting and core reads masked
        @(negedge clk);
        rst = 1'b0; c_wen = 1'b0;
        h_stb = 1'b1; h_we = 1'b1; h_addr = 8'd5; h_wdata = 8'hA5;
        for (int i = 0; i < 144; i++) begin
            c_ren = (i < 10); c_raddr = 8'd7;
            #1;
            chk("clr_wen", wen, 1'b1);
            chk("clr_waddr", waddr, i);
            chk("clr_wdata", wdata, 8'h00);
            chk("clr_ren", ren, 1'b0);
            chk("clr_ack", h_ack, 1'b0);
            chk("clr_done", init_done, 1'b0);
            @(negedge clk);
        end
        #1;
        chk("run_done", init_done, 1'b1);
        chk("hw_wen", wen, 1'b1);
        chk("hw_waddr", waddr, 8'd5);
        chk("hw_wdata", wdata, 8'hA5);
        chk("hw_ack_g", h_ack, 1'b0);
        @(negedge clk); #1;
        chk("hw_ack", h_ack, 1'b1);
        chk("hw_no_regrant", wen, 1'b0);
        @(negedge clk);
        h_stb = 1'b0;
        #1;
        chk("hw_ack_pulse", h_ack, 1'b0);

        // Host read of address 5 with core idle
        @(negedge clk);
        h_stb = 1'b1; h_we = 1'b0; h_addr = 8'd5;
        #1;
        chk("hr_ren", ren, 1'b1);
        chk("hr_raddr", raddr, 8'd5);
        @(negedge clk); #1;
        chk("hr_ack", h_ack, 1'b1);
        chk("hr_rdata", h_rdata, 8'hA5);
        chk("hr_no_regrant", ren, 1'b0);

        // Core write pass-through
        @(negedge clk);
        h_stb = 1'b0;
        c_wen = 1'b1; c_waddr = 8'd3; c_wdata = 8'h3C;
        #1;
        chk("cw_wen", wen, 1'b1);
        chk("cw_waddr", waddr, 8'd3);
        chk("cw_wdata", wdata, 8'h3C);

        // Host read stalled by 10 cycles of core reads
        @(negedge clk);
        c_wen = 1'b0; c_ren = 1'b1; c_raddr = 8'd3;
        h_stb = 1'b1; h_we = 1'b0; h_addr = 8'd5;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("stall_ren", ren, 1'b1);
            chk("stall_raddr", raddr, 8'd3);
            chk("stall_ack", h_ack, 1'b0);
            if (i > 0) chk("stall_crdata", c_rdata, 8'h3C);
            @(negedge clk);
        end
        c_ren = 1'b0;
        #1;
        chk("stall_grant_ren", ren, 1'b1);
        chk("stall_grant_raddr", raddr, 8'd5);
        chk("stall_last_crdata", c_rdata, 8'h3C);
        @(negedge clk); #1;
        chk("stall_ack_done", h_ack, 1'b1);
        chk("stall_rdata", h_rdata, 8'hA5);

        // Host read alongside a core write to another address
        @(negedge clk);
        c_wen = 1'b1; c_waddr = 8'd9; c_wdata = 8'h77;
        #1;
        chk("mix_ren", ren, 1'b1);
        chk("mix_raddr", raddr, 8'd5);
        chk("mix_wen", wen, 1'b1);
        chk("mix_waddr", waddr, 8'd9);
        chk("mix_wdata", wdata, 8'h77);
        @(negedge clk);
        c_wen = 1'b0;
        #1;
        chk("mix_ack", h_ack, 1'b1);
        chk("mix_rdata", h_rdata, 8'hA5);

        // Host write blocked by a core write, granted the next cycle
        @(negedge clk);
        h_stb = 1'b1; h_we = 1'b1; h_addr = 8'd9; h_wdata = 8'h11;
        c_wen = 1'b1; c_waddr = 8'd10; c_wdata = 8'h22;
        #1;
        chk("blk_waddr", waddr, 8'd10);
        chk("blk_wdata", wdata, 8'h22);
        chk("blk_ack", h_ack, 1'b0);
        @(negedge clk);
        c_wen = 1'b0;
        #1;
        chk("blk_grant_wen", wen, 1'b1);
        chk("blk_grant_waddr", waddr, 8'd9);
        chk("blk_grant_wdata", wdata, 8'h11);
        @(negedge clk); #1;
        chk("blk_ack_done", h_ack, 1'b1);
        @(negedge clk);
        h_stb = 1'b0; c_ren = 1'b1; c_raddr = 8'd9;
        @(negedge clk);
        c_ren = 1'b0;
        #1;
        chk("blk_readback", c_rdata, 8'h11);

        // Reset between grant and ack aborts the host access
        @(negedge clk);
        h_stb = 1'b1; h_we = 1'b1; h_addr = 8'd20; h_wdata = 8'h55;
        #1;
        chk("hab_waddr", waddr, 8'd20);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("hab_ack", h_ack, 1'b0);
        chk("hab_done", init_done, 1'b0);
        @(negedge clk);
        rst = 1'b0; h_stb = 1'b0;
        #1;
        chk("hab_restart_wen", wen, 1'b1);
        chk("hab_restart_addr", waddr, 8'd0);
        chk("hab_restart_ack", h_ack, 1'b0);
        @(negedge clk); #1;
        chk("hab_restart_addr1", waddr, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
